// File: rtl/nunchuck_responder.sv
// I2C target emulating a Wii Nunchuck: accepts the two-write init handshake
// and returns a six-byte snapshot of stick, accelerometer and button inputs.
module nunchuck_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h52,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] stick_X,
  input  logic [7:0] stick_Y,
  input  logic [9:0] accel_X,
  input  logic [9:0] accel_Y,
  input  logic [9:0] accel_Z,
  input  logic       z,
  input  logic       c,
  output logic       initialized,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic        scl_s, sda_s, scl_d, sda_d;
  logic        scl_rise, scl_fall, start_det, stop_det;

  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [7:0]  tx, tx_nxt;
  logic [7:0]  reg_ptr, reg_ptr_nxt;
  logic [47:0] snap, snap_nxt;
  logic [7:0]  rd_byte;
  logic        rw, rw_nxt, first_byte, first_byte_nxt, mack, mack_nxt;
  logic        init_stage, init_stage_nxt, initialized_nxt, busy_nxt, sda_oe_nxt;

  // Idle bus is high on both lines, so the chain resets to 1 to avoid a false edge.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  always_comb begin
    rd_byte = 8'hFF;
    if (initialized) begin
      case (reg_ptr)
        8'd0:    rd_byte = snap[47:40];
        8'd1:    rd_byte = snap[39:32];
        8'd2:    rd_byte = snap[31:24];
        8'd3:    rd_byte = snap[23:16];
        8'd4:    rd_byte = snap[15:8];
        8'd5:    rd_byte = snap[7:0];
        default: rd_byte = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shreg       <= 8'd0;
      tx          <= 8'd0;
      reg_ptr     <= 8'd0;
      snap        <= 48'd0;
      rw          <= 1'b0;
      first_byte  <= 1'b0;
      mack        <= 1'b0;
      init_stage  <= 1'b0;
      initialized <= 1'b0;
      busy        <= 1'b0;
      sda_oe      <= 1'b0;
    end else begin
      state       <= next_state;
      bit_cnt     <= bit_cnt_nxt;
      shreg       <= shreg_nxt;
      tx          <= tx_nxt;
      reg_ptr     <= reg_ptr_nxt;
      snap        <= snap_nxt;
      rw          <= rw_nxt;
      first_byte  <= first_byte_nxt;
      mack        <= mack_nxt;
      init_stage  <= init_stage_nxt;
      initialized <= initialized_nxt;
      busy        <= busy_nxt;
      sda_oe      <= sda_oe_nxt;
    end
  end

  always_comb begin
    next_state = state;
    if (start_det) next_state = ADDR;
    else if (stop_det) next_state = IDLE;
    else begin
      case (state)
        ADDR:     if (scl_fall && bit_cnt == 4'd8)
                    next_state = (shreg[7:1] == DEV_ADDR) ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (scl_fall) next_state = rw ? RD_BYTE : WR_BYTE;
        WR_BYTE:  if (scl_fall && bit_cnt == 4'd8) next_state = WR_ACK;
        WR_ACK:   if (scl_fall) next_state = WR_BYTE;
        RD_BYTE:  if (scl_fall && bit_cnt == 4'd8) next_state = RD_ACK;
        RD_ACK:   if (scl_fall) next_state = mack ? RD_BYTE : WAIT_STOP;
        default:  next_state = state;
      endcase
    end
  end

  // Loading a read byte drives its MSB right away; the rest shift out of tx on later SCL falls.
  always_comb begin
    bit_cnt_nxt     = bit_cnt;
    shreg_nxt       = shreg;
    tx_nxt          = tx;
    reg_ptr_nxt     = reg_ptr;
    snap_nxt        = snap;
    rw_nxt          = rw;
    first_byte_nxt  = first_byte;
    mack_nxt        = mack;
    init_stage_nxt  = init_stage;
    initialized_nxt = initialized;
    busy_nxt        = busy;
    sda_oe_nxt      = sda_oe;
    if (start_det) begin
      bit_cnt_nxt = 4'd0;
      sda_oe_nxt  = 1'b0;
    end else if (stop_det) begin
      bit_cnt_nxt = 4'd0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        ADDR, WR_BYTE: begin
          if (scl_rise) begin
            shreg_nxt   = {shreg[6:0], sda_s};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_nxt = 4'd0;
            if (state == ADDR) begin
              if (shreg[7:1] == DEV_ADDR) begin
                sda_oe_nxt     = 1'b1;
                busy_nxt       = 1'b1;
                rw_nxt         = shreg[0];
                first_byte_nxt = 1'b1;
                if (shreg[0])
                  snap_nxt = {stick_X, stick_Y, accel_X[9:2], accel_Y[9:2], accel_Z[9:2],
                              accel_Z[1:0], accel_Y[1:0], accel_X[1:0], ~c, ~z};
              end else begin
                sda_oe_nxt = 1'b0;
                busy_nxt   = 1'b0;
              end
            end else begin
              sda_oe_nxt = 1'b1;
              if (first_byte) begin
                reg_ptr_nxt    = shreg;
                first_byte_nxt = 1'b0;
              end else begin
                if (reg_ptr == 8'hF0 && shreg == 8'h55) init_stage_nxt = 1'b1;
                if (reg_ptr == 8'hFB && shreg == 8'h00 && init_stage) initialized_nxt = 1'b1;
                reg_ptr_nxt = reg_ptr + 8'd1;
              end
            end
          end
        end
        ADDR_ACK, WR_ACK, RD_ACK: begin
          if (scl_rise && state == RD_ACK) mack_nxt = ~sda_s;
          if (scl_fall) begin
            bit_cnt_nxt = 4'd0;
            if ((state == ADDR_ACK && rw) || (state == RD_ACK && mack)) begin
              sda_oe_nxt  = ~rd_byte[7];
              tx_nxt      = {rd_byte[6:0], 1'b1};
              reg_ptr_nxt = reg_ptr + 8'd1;
            end else begin
              sda_oe_nxt = 1'b0;
            end
          end
        end
        RD_BYTE: begin
          if (scl_rise) bit_cnt_nxt = bit_cnt + 4'd1;
          else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_nxt = 4'd0;
            sda_oe_nxt  = 1'b0;
          end else if (scl_fall && bit_cnt != 4'd0) begin
            sda_oe_nxt = ~tx[7];
            tx_nxt     = {tx[6:0], 1'b1};
          end
        end
        default: sda_oe_nxt = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_nunchuck_responder.sv
// Directed bench: an I2C master model on a wired-AND bus exercises init, reads,
// address mismatch, pointer wrap to 0xFF filler and mid-transfer reset.
module tb_nunchuck_responder;

  localparam int Q = 100;

  logic       clkin = 1'b0;
  logic       rst;
  logic       scl, sda_m;
  logic       sda_in, sda_oe;
  logic [7:0] stick_X, stick_Y;
  logic [9:0] accel_X, accel_Y, accel_Z;
  logic       z, c;
  logic       initialized, busy;

  int   check_count = 0;
  int   pass_count  = 0;
  logic ack;
  logic [7:0] rb;

  assign sda_in = sda_m & ~sda_oe;

  always #5 clkin = ~clkin;

  nunchuck_responder dut (
    .clkin(clkin), .rst(rst), .scl_in(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .stick_X(stick_X), .stick_Y(stick_Y), .accel_X(accel_X), .accel_Y(accel_Y),
    .accel_Z(accel_Z), .z(z), .c(c), .initialized(initialized), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #(Q);
    scl   = 1'b1; #(Q);
    sda_m = 1'b0; #(Q);
    scl   = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #(Q);
    scl   = 1'b1; #(Q);
    sda_m = 1'b1; #(Q);
  endtask

  task automatic i2c_write(input logic [7:0] b, output logic got_ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #(Q);
      scl = 1'b1; #(2*Q);
      scl = 1'b0; #(Q);
    end
    sda_m = 1'b1; #(Q);
    scl = 1'b1; #(Q);
    got_ack = ~sda_in; #(Q);
    scl = 1'b0; #(Q);
  endtask

  task automatic i2c_read(input logic give_ack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #(Q);
      scl = 1'b1; #(Q);
      b[i] = sda_in; #(Q);
      scl = 1'b0;
    end
    #(Q);
    sda_m = ~give_ack; #(Q);
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #(Q);
    sda_m = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] sx, input logic [7:0] sy, input logic [9:0] ax,
                               input logic [9:0] ay, input logic [9:0] az, input logic bz, input logic bc);
    stick_X = sx; stick_Y = sy; accel_X = ax; accel_Y = ay; accel_Z = az; z = bz; c = bc;
  endtask

  initial begin
    rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
    applyStimulus(8'h00, 8'h00, 10'h000, 10'h000, 10'h000, 1'b0, 1'b0);
    repeat (4) @(negedge clkin);
    checkOutput("reset_sda_oe", sda_oe, 8'h00);
    checkOutput("reset_busy", busy, 8'h00);
    checkOutput("reset_init", initialized, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clkin);

    // Init handshake: 0x55 to F0 then 0x00 to FB.
    i2c_start();
    i2c_write(8'hA4, ack); checkOutput("init1_addr_ack", ack, 8'h01);
    checkOutput("init1_busy", busy, 8'h01);
    i2c_write(8'hF0, ack); checkOutput("init1_reg_ack", ack, 8'h01);
    i2c_write(8'h55, ack); checkOutput("init1_data_ack", ack, 8'h01);
    i2c_stop();
    checkOutput("init1_busy_after_stop", busy, 8'h00);
    checkOutput("init1_not_yet", initialized, 8'h00);
    i2c_start();
    i2c_write(8'hA4, ack); checkOutput("init2_addr_ack", ack, 8'h01);
    i2c_write(8'hFB, ack); checkOutput("init2_reg_ack", ack, 8'h01);
    i2c_write(8'h00, ack); checkOutput("init2_data_ack", ack, 8'h01);
    i2c_stop();
    checkOutput("init2_initialized", initialized, 8'h01);

    // Full six-byte read after pointer write and repeated START.
    applyStimulus(8'h80, 8'h7F, 10'h201, 10'h202, 10'h303, 1'b1, 1'b0);
    i2c_start();
    i2c_write(8'hA4, ack); checkOutput("rd6_waddr_ack", ack, 8'h01);
    i2c_write(8'h00, ack); checkOutput("rd6_ptr_ack", ack, 8'h01);
    i2c_start();
    i2c_write(8'hA5, ack); checkOutput("rd6_raddr_ack", ack, 8'h01);
    i2c_read(1'b1, rb); checkOutput("rd6_b0", rb, 8'h80);
    i2c_read(1'b1, rb); checkOutput("rd6_b1", rb, 8'h7F);
    i2c_read(1'b1, rb); checkOutput("rd6_b2", rb, 8'h80);
    i2c_read(1'b1, rb); checkOutput("rd6_b3", rb, 8'h80);
    i2c_read(1'b1, rb); checkOutput("rd6_b4", rb, 8'hC0);
    i2c_read(1'b0, rb); checkOutput("rd6_b5", rb, 8'hE6);
    i2c_stop();

    // Wrong address: no ACK, not busy, data ignored.
    i2c_start();
    i2c_write(8'hA6, ack); checkOutput("badaddr_nack", ack, 8'h00);
    checkOutput("badaddr_busy", busy, 8'h00);
    i2c_write(8'h00, ack); checkOutput("badaddr_data_nack", ack, 8'h00);
    i2c_stop();

    // Pointer 4: B4, B5 then filler; inputs change mid-read.
    i2c_start();
    i2c_write(8'hA4, ack); checkOutput("p4_waddr_ack", ack, 8'h01);
    i2c_write(8'h04, ack); checkOutput("p4_ptr_ack", ack, 8'h01);
    i2c_stop();
    i2c_start();
    i2c_write(8'hA5, ack); checkOutput("p4_raddr_ack", ack, 8'h01);
    i2c_read(1'b1, rb); checkOutput("p4_b4", rb, 8'hC0);
    applyStimulus(8'h11, 8'h22, 10'h000, 10'h3FF, 10'h000, 1'b0, 1'b1);
    i2c_read(1'b1, rb); checkOutput("p4_b5_frozen", rb, 8'hE6);
    i2c_read(1'b1, rb); checkOutput("p4_b6_ff", rb, 8'hFF);
    i2c_read(1'b0, rb); checkOutput("p4_b7_ff", rb, 8'hFF);
    i2c_stop();

    // Reset during bit 3 of a read byte that is all zeros.
    applyStimulus(8'h00, 8'h00, 10'h000, 10'h000, 10'h000, 1'b0, 1'b0);
    i2c_start();
    i2c_write(8'hA4, ack); checkOutput("rst_waddr_ack", ack, 8'h01);
    i2c_write(8'h00, ack); checkOutput("rst_ptr_ack", ack, 8'h01);
    i2c_stop();
    i2c_start();
    i2c_write(8'hA5, ack); checkOutput("rst_raddr_ack", ack, 8'h01);
    for (int i = 0; i < 4; i++) begin
      #(Q); scl = 1'b1; #(2*Q); scl = 1'b0;
    end
    #(Q); scl = 1'b1; #(Q);
    checkOutput("rst_pre_drive", sda_oe, 8'h01);
    rst = 1'b1; #1;
    checkOutput("rst_async_release", sda_oe, 8'h00);
    checkOutput("rst_init_cleared", initialized, 8'h00);
    #19;
    rst = 1'b0;
    #(Q); scl = 1'b0; #(Q);
    i2c_stop();
    checkOutput("rst_idle_sda_oe", sda_oe, 8'h00);
    i2c_start();
    i2c_write(8'hA4, ack); checkOutput("post_rst_addr_ack", ack, 8'h01);
    i2c_write(8'h10, ack); checkOutput("post_rst_data_ack", ack, 8'h01);
    i2c_stop();

    // Not initialized: reads return filler, NACK releases the bus.
    i2c_start();
    i2c_write(8'hA5, ack); checkOutput("uninit_raddr_ack", ack, 8'h01);
    i2c_read(1'b1, rb); checkOutput("uninit_b0", rb, 8'hFF);
    i2c_read(1'b1, rb); checkOutput("uninit_b1", rb, 8'hFF);
    i2c_read(1'b0, rb); checkOutput("uninit_b2", rb, 8'hFF);
    checkOutput("uninit_nack_release", sda_oe, 8'h00);
    sda_m = 1'b0; #(Q);
    scl = 1'b1; #(Q);
    checkOutput("uninit_stop_release", sda_oe, 8'h00);
    sda_m = 1'b1; #(Q);
    checkOutput("uninit_busy_after_stop", busy, 8'h00);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
